// File: rtl/fetch_prefetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_prefetch_queue
//
// Instruction-fetch front end with an in-order prefetch buffer. It issues
// sequential fetch requests to instruction memory and buffers up to DEPTH
// instructions with their PCs. The head entry is presented to decode. A
// taken-branch redirect flushes the buffer, and responses to requests made
// before the redirect are discarded when they return.
//
// Parameters:
//   PC_W       PC / address width (PC wraps modulo 2^PC_W)
//   INSTR_W    instruction width
//   DEPTH      buffer slots (power of two, >= 2)
//   RESET_PC   first fetch address after reset
//   NOP_INSTR  instruction shown on instr_D while valid_D is low
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   redirect            taken branch: flush and refetch from redirect_pc
//   redirect_pc         new fetch address
//   stall_D             decode cannot accept the head entry this cycle
//   imem_req_valid      fetch request valid
//   imem_req_ready      memory accepts the request
//   imem_req_addr       fetch address
//   imem_rsp_valid      in-order response valid (always accepted)
//   imem_rsp_data       fetched instruction
//   valid_D             head entry valid for decode
//   instr_D             head instruction (NOP_INSTR when not valid)
//   pc_D                head PC (0 when not valid)
//   pc_plus4D           head PC + 4 (0 when not valid)
//   occupancy           allocated slots (filled + awaiting response)
// ---------------------------------------------------------------------------
module fetch_prefetch_queue #(
    parameter int                  PC_W      = 16,
    parameter int                  INSTR_W   = 32,
    parameter int                  DEPTH     = 4,
    parameter logic [PC_W-1:0]     RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = 32'h0000_0013
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          redirect,
    input  logic [PC_W-1:0]               redirect_pc,
    input  logic                          stall_D,
    output logic                          imem_req_valid,
    input  logic                          imem_req_ready,
    output logic [PC_W-1:0]               imem_req_addr,
    input  logic                          imem_rsp_valid,
    input  logic [INSTR_W-1:0]            imem_rsp_data,
    output logic                          valid_D,
    output logic [INSTR_W-1:0]            instr_D,
    output logic [PC_W-1:0]               pc_D,
    output logic [PC_W-1:0]               pc_plus4D,
    output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_X = (CW + 1)'(DEPTH);

    logic [PC_W-1:0]    fetch_pc_r;
    logic [PC_W-1:0]    pc_mem_r    [DEPTH];
    logic [INSTR_W-1:0] instr_mem_r [DEPTH];
    logic [DEPTH-1:0]   filled_r;
    logic [PW-1:0]      head_r;
    logic [PW-1:0]      alloc_ptr_r;
    logic [PW-1:0]      fill_ptr_r;
    logic [CW-1:0]      alloc_cnt_r;
    logic [CW-1:0]      unfill_cnt_r;
    logic [CW-1:0]      drop_cnt_r;

    logic               accept_s;
    logic               rsp_drop_s;
    logic               rsp_fill_s;
    logic               pop_s;
    logic [CW:0]        inflight_s;
    logic [CW-1:0]      outstanding_s;
    logic [CW-1:0]      redir_drop_s;
    logic [DEPTH-1:0]   filled_next_s;

    // Request generation and response / pop qualification.
    always_comb begin
        // Stale responses still in flight occupy memory-side capacity, so
        // they count against the buffer limit until they have drained.
        inflight_s     = {1'b0, alloc_cnt_r} + {1'b0, drop_cnt_r};
        imem_req_valid = !reset && !redirect && (alloc_cnt_r < DEPTH_C)
                         && (inflight_s < DEPTH_X);
        imem_req_addr  = fetch_pc_r;
        accept_s       = imem_req_valid && imem_req_ready;
        rsp_drop_s     = imem_rsp_valid && (drop_cnt_r != '0);
        rsp_fill_s     = imem_rsp_valid && (drop_cnt_r == '0)
                         && (unfill_cnt_r != '0);
        valid_D        = filled_r[head_r];
        pop_s          = valid_D && !stall_D && !redirect;
    end

    // Number of responses still owed to the memory after a redirect; a
    // response arriving in the redirect cycle settles one of them.
    always_comb begin
        outstanding_s = drop_cnt_r + unfill_cnt_r;
        if (imem_rsp_valid && (outstanding_s != '0)) begin
            redir_drop_s = outstanding_s - CW'(1);
        end else begin
            redir_drop_s = outstanding_s;
        end
    end

    // Per-slot filled flag: accept, fill and pop never target the same slot.
    always_comb begin
        filled_next_s = filled_r;
        for (int i = 0; i < DEPTH; i++) begin
            if (accept_s && (alloc_ptr_r == PW'(i))) begin
                filled_next_s[i] = 1'b0;
            end else if (rsp_fill_s && (fill_ptr_r == PW'(i))) begin
                filled_next_s[i] = 1'b1;
            end else if (pop_s && (head_r == PW'(i))) begin
                filled_next_s[i] = 1'b0;
            end else begin
                filled_next_s[i] = filled_r[i];
            end
        end
    end

    // Buffer state, pointers, counters and fetch PC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_r   <= RESET_PC;
            filled_r     <= '0;
            head_r       <= '0;
            alloc_ptr_r  <= '0;
            fill_ptr_r   <= '0;
            alloc_cnt_r  <= '0;
            unfill_cnt_r <= '0;
            drop_cnt_r   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]    <= '0;
                instr_mem_r[i] <= '0;
            end
        end else if (redirect) begin
            fetch_pc_r   <= redirect_pc;
            filled_r     <= '0;
            head_r       <= '0;
            alloc_ptr_r  <= '0;
            fill_ptr_r   <= '0;
            alloc_cnt_r  <= '0;
            unfill_cnt_r <= '0;
            drop_cnt_r   <= redir_drop_s;
        end else begin
            filled_r <= filled_next_s;

            if (accept_s) begin
                pc_mem_r[alloc_ptr_r] <= fetch_pc_r;
                alloc_ptr_r           <= alloc_ptr_r + PW'(1);
                fetch_pc_r            <= fetch_pc_r + PC_W'(4);
            end else begin
                fetch_pc_r <= fetch_pc_r;
            end

            if (rsp_fill_s) begin
                instr_mem_r[fill_ptr_r] <= imem_rsp_data;
                fill_ptr_r              <= fill_ptr_r + PW'(1);
            end else begin
                fill_ptr_r <= fill_ptr_r;
            end

            if (pop_s) begin
                head_r <= head_r + PW'(1);
            end else begin
                head_r <= head_r;
            end

            if (rsp_drop_s) begin
                drop_cnt_r <= drop_cnt_r - CW'(1);
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end

            case ({accept_s, pop_s})
                2'b10:   alloc_cnt_r <= alloc_cnt_r + CW'(1);
                2'b01:   alloc_cnt_r <= alloc_cnt_r - CW'(1);
                default: alloc_cnt_r <= alloc_cnt_r;
            endcase

            case ({accept_s, rsp_fill_s})
                2'b10:   unfill_cnt_r <= unfill_cnt_r + CW'(1);
                2'b01:   unfill_cnt_r <= unfill_cnt_r - CW'(1);
                default: unfill_cnt_r <= unfill_cnt_r;
            endcase
        end
    end

    // Decode-facing view of the head slot, with bubble values when empty.
    always_comb begin
        if (valid_D) begin
            instr_D   = instr_mem_r[head_r];
            pc_D      = pc_mem_r[head_r];
            pc_plus4D = pc_mem_r[head_r] + PC_W'(4);
        end else begin
            instr_D   = NOP_INSTR;
            pc_D      = '0;
            pc_plus4D = '0;
        end
        occupancy = alloc_cnt_r;
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_prefetch_queue
//
// Directed bench for fetch_prefetch_queue (default parameters). A small
// in-order instruction memory with configurable latency answers every
// accepted request with data derived from its address. Inputs change on the
// falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_fetch_prefetch_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        stall_D;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [15:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        valid_D;
    logic [31:0] instr_D;
    logic [15:0] pc_D;
    logic [15:0] pc_plus4D;
    logic [2:0]  occupancy;

    fetch_prefetch_queue dut (
        .clk            (clk),
        .reset          (reset),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .stall_D        (stall_D),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .valid_D        (valid_D),
        .instr_D        (instr_D),
        .pc_D           (pc_D),
        .pc_plus4D      (pc_plus4D),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_miscompare = 0;
    int          cyc;
    int          lat;
    int          accepts;
    bit          stall;
    bit          rdy;
    bit          rand_rdy;
    bit          rand_stall;
    bit          redir;
    logic [15:0] rpc;
    logic [15:0] exp_pc;
    logic [15:0] exp_p4;
    logic [15:0] exp_addr;
    logic [15:0] mq_addr[$];
    int          mq_due[$];

    function automatic logic [31:0] data_of(input logic [15:0] a);
        return {16'hC0DE, a};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miscompare++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive memory and stimulus, then run the running checks.
    task automatic step();
        @(negedge clk);
        cyc++;
        reset = 1'b0;
        if (rand_rdy)   rdy   = 1'($urandom_range(0, 1));
        if (rand_stall) stall = ($urandom_range(0, 3) == 0);
        if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = data_of(mq_addr[0]);
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        imem_req_ready = rdy;
        stall_D        = stall;
        redirect       = redir;
        redirect_pc    = rpc;
        #1;
        if (imem_req_valid && imem_req_ready) begin
            check_eq("req_addr_order", {16'h0, imem_req_addr}, {16'h0, exp_addr});
            mq_addr.push_back(imem_req_addr);
            mq_due.push_back(cyc + lat);
            exp_addr = exp_addr + 16'd4;
            accepts++;
        end
        if (valid_D && !stall && !redir) begin
            exp_p4 = exp_pc + 16'd4;
            check_eq("pop_pc",     {16'h0, pc_D},      {16'h0, exp_pc});
            check_eq("pop_pc4",    {16'h0, pc_plus4D}, {16'h0, exp_p4});
            check_eq("pop_instr",  instr_D,            data_of(exp_pc));
            exp_pc = exp_p4;
        end
        if (!valid_D) begin
            check_eq("bubble_instr", instr_D, NOP);
            check_eq("bubble_pc",    {16'h0, pc_D}, 32'h0);
        end
        check_eq("occ_le_depth", {31'h0, occupancy <= 3'd4}, 32'h1);
        if (redir) begin
            exp_pc   = rpc;
            exp_addr = rpc;
        end
    endtask

    // Assert reset asynchronously (mid-cycle) and check the reset state.
    task automatic do_reset();
        @(negedge clk);
        reset          = 1'b1;
        redir          = 1'b0;
        stall          = 1'b0;
        rdy            = 1'b1;
        rand_rdy       = 1'b0;
        rand_stall     = 1'b0;
        redirect       = 1'b0;
        stall_D        = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        mq_addr.delete();
        mq_due.delete();
        #1;
        check_eq("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        check_eq("rst_valid_D",   {31'h0, valid_D},        32'h0);
        check_eq("rst_instr_D",   instr_D,                 NOP);
        check_eq("rst_pc_D",      {16'h0, pc_D},           32'h0);
        check_eq("rst_pc4",       {16'h0, pc_plus4D},      32'h0);
        check_eq("rst_occ",       {29'h0, occupancy},      32'h0);
        check_eq("rst_addr",      {16'h0, imem_req_addr},  32'h0);
        cyc      = -1;
        accepts  = 0;
        exp_pc   = 16'h0000;
        exp_addr = 16'h0000;
    endtask

    initial begin
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'h0;
        rpc         = 16'h0;
        lat         = 1;

        // Streaming with a 1-cycle memory.
        do_reset();
        lat = 1;
        step();
        check_eq("t1_c0_req_valid", {31'h0, imem_req_valid}, 32'h1);
        check_eq("t1_c0_addr",      {16'h0, imem_req_addr},  32'h0);
        check_eq("t1_c0_valid_D",   {31'h0, valid_D},        32'h0);
        step();
        check_eq("t1_c1_valid_D",   {31'h0, valid_D},        32'h0);
        check_eq("t1_c1_occ",       {29'h0, occupancy},      32'h1);
        check_eq("t1_c1_addr",      {16'h0, imem_req_addr},  32'h4);
        step();
        check_eq("t1_c2_valid_D",   {31'h0, valid_D},        32'h1);
        check_eq("t1_c2_pc_D",      {16'h0, pc_D},           32'h0);
        check_eq("t1_c2_pc4",       {16'h0, pc_plus4D},      32'h4);
        check_eq("t1_c2_occ",       {29'h0, occupancy},      32'h2);
        step();
        check_eq("t1_c3_pc_D",      {16'h0, pc_D},           32'h4);
        step();
        check_eq("t1_c4_pc_D",      {16'h0, pc_D},           32'h8);

        // Stall until full, then drain without gaps.
        do_reset();
        stall = 1'b1;
        repeat (10) step();
        check_eq("t2_accepts",    accepts,                  32'd4);
        check_eq("t2_req_valid",  {31'h0, imem_req_valid},  32'h0);
        check_eq("t2_occ_full",   {29'h0, occupancy},       32'h4);
        check_eq("t2_head_pc",    {16'h0, pc_D},            32'h0);
        stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("t2_drain_valid", {31'h0, valid_D}, 32'h1);
            check_eq("t2_drain_pc",    {16'h0, pc_D},    32'(i * 4));
            if (i == 1) begin
                check_eq("t2_resume_valid", {31'h0, imem_req_valid}, 32'h1);
                check_eq("t2_resume_addr",  {16'h0, imem_req_addr},  32'h10);
            end
        end

        // Redirect with two requests outstanding on a 3-cycle memory.
        do_reset();
        lat = 3;
        step();
        step();
        redir = 1'b1;
        rpc   = 16'h0100;
        step();
        check_eq("t3_redir_req_valid", {31'h0, imem_req_valid}, 32'h0);
        check_eq("t3_redir_occ",       {29'h0, occupancy},      32'h2);
        redir = 1'b0;
        step();
        check_eq("t3_new_req_valid", {31'h0, imem_req_valid}, 32'h1);
        check_eq("t3_new_addr",      {16'h0, imem_req_addr},  32'h0100);
        check_eq("t3_occ_flushed",   {29'h0, occupancy},      32'h0);
        check_eq("t3_stale_rsp",     {31'h0, imem_rsp_valid}, 32'h1);
        check_eq("t3_valid_D_c3",    {31'h0, valid_D},        32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("t3_valid_D_wait", {31'h0, valid_D}, 32'h0);
        end
        step();
        check_eq("t3_first_valid", {31'h0, valid_D}, 32'h1);
        check_eq("t3_first_pc",    {16'h0, pc_D},    32'h0100);
        check_eq("t3_first_instr", instr_D,          data_of(16'h0100));

        // Redirect in the same cycle as a pop and a response.
        do_reset();
        lat = 1;
        step();
        step();
        step();
        redir = 1'b1;
        rpc   = 16'h0200;
        step();
        check_eq("t4_head_pc",    {16'h0, pc_D},           32'h4);
        check_eq("t4_rsp_valid",  {31'h0, imem_rsp_valid}, 32'h1);
        check_eq("t4_req_valid",  {31'h0, imem_req_valid}, 32'h0);
        redir = 1'b0;
        step();
        check_eq("t4_after_valid_D", {31'h0, valid_D},        32'h0);
        check_eq("t4_after_addr",    {16'h0, imem_req_addr},  32'h0200);
        check_eq("t4_after_req",     {31'h0, imem_req_valid}, 32'h1);
        check_eq("t4_after_occ",     {29'h0, occupancy},      32'h0);
        step();
        check_eq("t4_c5_valid_D", {31'h0, valid_D}, 32'h0);
        step();
        check_eq("t4_c6_valid_D", {31'h0, valid_D}, 32'h1);
        check_eq("t4_c6_pc_D",    {16'h0, pc_D},    32'h0200);

        // PC wrap at the top of the address space.
        redir = 1'b1;
        rpc   = 16'hFFFC;
        step();
        redir = 1'b0;
        step();
        check_eq("t5_addr_top",  {16'h0, imem_req_addr}, 32'hFFFC);
        step();
        check_eq("t5_addr_wrap", {16'h0, imem_req_addr}, 32'h0000);
        step();
        check_eq("t5_head_top",  {16'h0, pc_D},          32'hFFFC);
        check_eq("t5_pc4_wrap",  {16'h0, pc_plus4D},     32'h0000);
        step();
        check_eq("t5_head_wrap", {16'h0, pc_D},          32'h0000);
        check_eq("t5_pc4_next",  {16'h0, pc_plus4D},     32'h0004);

        // Random ready / stall with occasional redirects on a 2-cycle memory.
        do_reset();
        lat        = 2;
        rand_rdy   = 1'b1;
        rand_stall = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ((i % 60) == 59) begin
                redir = 1'b1;
                rpc   = 16'($urandom_range(0, 16383)) << 2;
            end else begin
                redir = 1'b0;
            end
            step();
        end
        redir      = 1'b0;
        rand_rdy   = 1'b0;
        rand_stall = 1'b0;
        rdy        = 1'b1;
        stall      = 1'b0;
        repeat (10) step();
        check_eq("t6_streaming", {31'h0, valid_D}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch_queue.md
# fetch_prefetch_queue

Parametrised instruction-fetch front end with an in-order prefetch buffer. It sits between the instruction memory and the decode stage. It issues sequential fetch requests over a valid/ready port and buffers up to DEPTH instructions with their PCs. It presents them to decode with a stall input, and on a taken-branch redirect it flushes the buffer and discards in-flight responses. Compared with a single-register fetch stage, it adds fetch decoupling, a memory handshake, configurable depth/widths and squash of stale responses.

## Interface
- PC_W, 16, PC/address width; PC wraps modulo 2^PC_W
- INSTR_W, 32, instruction width
- DEPTH, 4, buffer slots; power of two, >= 2
- RESET_PC, 0, first fetch address after reset
- NOP_INSTR, 32'h00000013, value driven on instr_D when valid_D=0
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- redirect  in  1  taken branch/jump; flush and refetch
- redirect_pc  in  PC_W  new fetch address
- stall_D  in  1  decode cannot accept this cycle
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  PC_W  fetch address
- imem_rsp_valid  in  1  response valid; responses return in request order, always accepted
- imem_rsp_data  in  INSTR_W  fetched instruction
- valid_D  out  1  head entry valid for decode
- instr_D  out  INSTR_W  head instruction (NOP_INSTR when valid_D=0)
- pc_D  out  PC_W  head PC (0 when valid_D=0)
- pc_plus4D  out  PC_W  pc_D+4 mod 2^PC_W (0 when valid_D=0)
- occupancy  out  $clog2(DEPTH+1)  allocated slots (filled + awaiting response)

## Operation
- State: fetch_pc; circular buffer of DEPTH slots {pc, instr, filled}; head/alloc/fill pointers; alloc count; drop_cnt ($clog2(DEPTH+1) bits).
- Request: imem_req_valid = !reset && !redirect && alloc_count < DEPTH && (alloc_count + drop_cnt) < DEPTH. imem_req_addr = fetch_pc.
- Accept (valid && ready): allocate the slot at the alloc pointer with pc=fetch_pc and filled=0. Then fetch_pc += 4 (wraps).
- Response with drop_cnt>0: discard the data and decrement drop_cnt.
- Response with drop_cnt=0: write the instruction into the oldest unfilled slot and set filled=1. A response with no unfilled slot is a protocol error and is ignored.
- Dequeue: valid_D = head slot filled. Pop when valid_D && !stall_D && !redirect.
- Redirect (priority over everything):
  - Clear all slots. alloc_count becomes 0.
  - drop_cnt += number of allocated-but-unfilled slots. Add 1 more if imem_rsp_valid is low this cycle... no: a response arriving in the redirect cycle is itself discarded and is not counted.
  - fetch_pc = redirect_pc. No request is issued in the redirect cycle.
- Same-cycle accept + response + pop are all legal. Occupancy updates by (+accept − pop).
- Pointer arithmetic is modulo DEPTH.
- Full: alloc_count=DEPTH, so requests are held off. Empty: valid_D=0 and outputs show bubble values.

## Timing
- Reset (async assert): fetch_pc=RESET_PC, all slots cleared, drop_cnt=0, valid_D=0, instr_D=NOP_INSTR, pc_D=0, pc_plus4D=0, occupancy=0, imem_req_valid=0.
- First cycle after reset deasserts: imem_req_valid=1 with addr=RESET_PC.
- Latency: a response sampled at edge t gives valid_D=1 in cycle t+1 (registered buffer, combinational head read). With a 1-cycle memory that is always ready, request→valid_D takes 2 cycles.
- Throughput: one instruction per cycle sustained when memory latency L satisfies L+1 <= DEPTH.
- Redirect sampled at edge t: valid_D=0 from t+1, first request to redirect_pc in cycle t+1. Stale responses are discarded until drop_cnt=0.
- Reset mid-flight: all state is lost. Responses arriving after reset deassert that belong to pre-reset requests are the environment's responsibility (memory is reset together with this block).

## Test plan
- Reset, RESET_PC=0, 1-cycle always-ready memory, stall_D=0 -> requests 0,4,8,... on consecutive cycles. valid_D first high 2 cycles after reset release, then pc_D=0,4,8 on consecutive cycles with pc_plus4D=pc_D+4.
- stall_D held high for 10 cycles, DEPTH=4 -> exactly 4 requests accepted, then imem_req_valid=0 and occupancy=4. On release, pc_D 0,4,8,12 are drained in order with no gap and fetching resumes at 16.
- 3-cycle memory latency, 2 requests outstanding, redirect with redirect_pc=0x0100 -> drop_cnt=2. Both stale responses are discarded and the first valid_D shows pc_D=0x0100 with the data from the new fetch.
- Redirect in the same cycle as a pop and a response -> no pop occurs, the response is discarded, and the next cycle has valid_D=0 and fetch address=redirect_pc.
- fetch_pc=0xFFFC with PC_W=16 -> next request address is 0x0000, and pc_plus4D for head 0xFFFC is 0x0000.
- imem_req_ready toggling 0/1 randomly -> PC sequence stays gap-free and in order, and occupancy never exceeds DEPTH.
